mastermind_scorer: RTL and testbench

- Datapath stage directly downstream of the Mastermind control FSM.
- Holds the secret code and the current guess, each four pegs.
- Consumes the FSM's compare sequence (compare_i 0..3, with reach_result_3 on the last step) and scores the guess serially, one peg per cycle. The score is black pegs (right colour, right place) and white pegs (right colour, wrong place).
- Tracks the guess count and win/lose status for the display stage.

---
 rtl/mastermind_pkg.sv | 11 +
 rtl/mastermind_scorer_if.sv | 31 +++
 rtl/mastermind_peg_match.sv | 23 ++
 rtl/mastermind_scorer.sv | 150 +++++++++++++++
 tb/tb_mastermind_scorer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mastermind_pkg.sv
// Shared types and sizes for the Mastermind scoring datapath.
package mastermind_pkg;
    localparam int NUM_PEGS = 4;
    localparam int COLOR_W  = 3;

    typedef logic [COLOR_W-1:0]     colour_t;
    typedef logic [2:0]             score_t;
    typedef logic [1:0]             peg_idx_t;
    typedef logic [NUM_PEGS-1:0]    peg_mask_t;
    typedef colour_t [NUM_PEGS-1:0] peg_vec_t;
endpackage

// File: rtl/mastermind_scorer_if.sv
// Control strobes from the Mastermind FSM and score/status back to the display stage.
interface mastermind_scorer_if;
    import mastermind_pkg::*;

    colour_t  colour_in;
    logic     load_code_1, load_code_2, load_code_3, load_code_4;
    logic     load_guess_1, load_guess_2, load_guess_3, load_guess_4;
    logic     compare;
    peg_idx_t compare_i;
    logic     reach_result_3;
    score_t   black_count;
    score_t   white_count;
    logic     result_valid;
    logic [3:0] guess_count;
    logic     win;
    logic     lose;

    modport master (
        output colour_in, load_code_1, load_code_2, load_code_3, load_code_4,
               load_guess_1, load_guess_2, load_guess_3, load_guess_4,
               compare, compare_i, reach_result_3,
        input  black_count, white_count, result_valid, guess_count, win, lose
    );

    modport slave (
        input  colour_in, load_code_1, load_code_2, load_code_3, load_code_4,
               load_guess_1, load_guess_2, load_guess_3, load_guess_4,
               compare, compare_i, reach_result_3,
        output black_count, white_count, result_valid, guess_count, win, lose
    );
endinterface

// File: rtl/mastermind_peg_match.sv
// Finds the lowest code position that can award a white peg to one guess colour.
module mastermind_peg_match
    import mastermind_pkg::*;
(
    input  colour_t   guess_colour,
    input  peg_vec_t  code,
    input  peg_mask_t ex,
    input  peg_mask_t used,
    output logic      hit,
    output peg_mask_t sel
);
    peg_mask_t elig;

    generate
        for (genvar gi = 0; gi < NUM_PEGS; gi++) begin : g_elig
            assign elig[gi] = (code[gi] == guess_colour) && !ex[gi] && !used[gi];
        end
    endgenerate

    // Isolate the lowest set bit: lowest eligible position wins.
    assign sel = elig & (~elig + peg_mask_t'(1));
    assign hit = |elig;
endmodule

// File: rtl/mastermind_scorer.sv
// Holds code/guess registers, scores a guess serially one peg per compare step,
// and tracks guess count and win/lose status.
module mastermind_scorer
    import mastermind_pkg::*;
#(
    parameter int MAX_GUESSES = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    mastermind_scorer_if.slave   bus
);
    localparam logic [3:0] MAX_G = 4'(MAX_GUESSES);

    peg_vec_t   code_q, code_d, guess_q, guess_d;
    peg_mask_t  used_q, used_d;
    peg_idx_t   exp_i_q, exp_i_d;
    logic       seq_ok_q, seq_ok_d;
    score_t     blk_acc_q, blk_acc_d, wht_acc_q, wht_acc_d;
    score_t     black_q, black_d, white_q, white_d;
    logic       valid_q, valid_d;
    logic [3:0] gcount_q, gcount_d;
    logic       win_q, win_d, lose_q, lose_d;

    peg_mask_t  lc, lg, ex, used_base, sel;
    score_t     blk_base, wht_base;
    logic       hit, start, step_ok, game_over;
    peg_idx_t   idx;

    assign lc = {bus.load_code_4, bus.load_code_3, bus.load_code_2, bus.load_code_1};
    assign lg = {bus.load_guess_4, bus.load_guess_3, bus.load_guess_2, bus.load_guess_1};
    assign idx       = bus.compare_i;
    assign start     = (idx == 2'd0);
    assign step_ok   = start || (seq_ok_q && (idx == exp_i_q));
    assign game_over = win_q | lose_q;

    generate
        for (genvar gi = 0; gi < NUM_PEGS; gi++) begin : g_exact
            assign ex[gi] = (guess_q[gi] == code_q[gi]);
        end
    endgenerate

    // A new sequence scores peg 0 against a cleared mask and accumulators.
    assign used_base = start ? '0 : used_q;
    assign blk_base  = start ? '0 : blk_acc_q;
    assign wht_base  = start ? '0 : wht_acc_q;

    mastermind_peg_match u_match (
        .guess_colour (guess_q[idx]),
        .code         (code_q),
        .ex           (ex),
        .used         (used_base),
        .hit          (hit),
        .sel          (sel)
    );

    always_comb begin
        code_d    = code_q;
        guess_d   = guess_q;
        used_d    = used_q;
        exp_i_d   = exp_i_q;
        seq_ok_d  = seq_ok_q;
        blk_acc_d = blk_acc_q;
        wht_acc_d = wht_acc_q;
        black_d   = black_q;
        white_d   = white_q;
        valid_d   = valid_q;
        gcount_d  = gcount_q;
        win_d     = win_q;
        lose_d    = lose_q;

        for (int n = 0; n < NUM_PEGS; n++) begin
            if (lc[n]) code_d[n] = bus.colour_in;
            if (lg[n] && !game_over) guess_d[n] = bus.colour_in;
        end

        if (bus.compare && !game_over) begin
            if (start) valid_d = 1'b0;
            if (!step_ok) begin
                seq_ok_d = 1'b0;
            end else begin
                seq_ok_d  = 1'b1;
                used_d    = used_base;
                blk_acc_d = blk_base;
                wht_acc_d = wht_base;
                if (ex[idx]) begin
                    blk_acc_d = blk_base + 3'd1;
                end else if (hit) begin
                    used_d    = used_base | sel;
                    wht_acc_d = wht_base + 3'd1;
                end
                exp_i_d = idx + 2'd1;
                if (bus.reach_result_3 && (idx == 2'd3)) begin
                    black_d = blk_acc_d;
                    white_d = wht_acc_d;
                    valid_d = 1'b1;
                    if (gcount_q < MAX_G) gcount_d = gcount_q + 4'd1;
                    win_d  = (blk_acc_d == 3'd4);
                    lose_d = (blk_acc_d != 3'd4) && (gcount_q + 4'd1 == MAX_G);
                end
            end
        end

        // Loading the first code peg starts a new game.
        if (lc[0]) begin
            gcount_d = '0;
            win_d    = 1'b0;
            lose_d   = 1'b0;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q    <= '0;
            guess_q   <= '0;
            used_q    <= '0;
            exp_i_q   <= '0;
            seq_ok_q  <= 1'b0;
            blk_acc_q <= '0;
            wht_acc_q <= '0;
            black_q   <= '0;
            white_q   <= '0;
            valid_q   <= 1'b0;
            gcount_q  <= '0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            code_q    <= code_d;
            guess_q   <= guess_d;
            used_q    <= used_d;
            exp_i_q   <= exp_i_d;
            seq_ok_q  <= seq_ok_d;
            blk_acc_q <= blk_acc_d;
            wht_acc_q <= wht_acc_d;
            black_q   <= black_d;
            white_q   <= white_d;
            valid_q   <= valid_d;
            gcount_q  <= gcount_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
        end
    end

    assign bus.black_count  = black_q;
    assign bus.white_count  = white_q;
    assign bus.result_valid = valid_q;
    assign bus.guess_count  = gcount_q;
    assign bus.win          = win_q;
    assign bus.lose         = lose_q;
endmodule

// File: tb/tb_mastermind_scorer.sv
// Directed bench for mastermind_scorer: table of code/guess scores plus multi-cycle corner sequences.
module tb_mastermind_scorer;
    import mastermind_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mastermind_scorer_if bus();
    logic [3:0] lc, lg;

    assign bus.load_code_1  = lc[0];
    assign bus.load_code_2  = lc[1];
    assign bus.load_code_3  = lc[2];
    assign bus.load_code_4  = lc[3];
    assign bus.load_guess_1 = lg[0];
    assign bus.load_guess_2 = lg[1];
    assign bus.load_guess_3 = lg[2];
    assign bus.load_guess_4 = lg[3];

    mastermind_scorer #(.MAX_GUESSES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [11:0] code;
        logic [11:0] guess;
        logic [2:0]  eb;
        logic [2:0]  ew;
        logic        ewin;
    } vec_t;

    vec_t vecs [7];
    int n_pass = 0;
    int n_total = 0;

    function automatic logic [11:0] p4(int c0, int c1, int c2, int c3);
        return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_out(string tag, int eb, int ew, int erv, int egc, int ewin, int elose);
        check({tag, ".black"}, int'(bus.black_count), eb);
        check({tag, ".white"}, int'(bus.white_count), ew);
        check({tag, ".valid"}, int'(bus.result_valid), erv);
        check({tag, ".gcount"}, int'(bus.guess_count), egc);
        check({tag, ".win"}, int'(bus.win), ewin);
        check({tag, ".lose"}, int'(bus.lose), elose);
        $display("%s: black=%0d white=%0d valid=%0d gcount=%0d win=%0d lose=%0d", tag,
                 bus.black_count, bus.white_count, bus.result_valid, bus.guess_count,
                 bus.win, bus.lose);
    endtask

    task automatic idle();
        lc = '0;
        lg = '0;
        bus.colour_in = '0;
        bus.compare = 1'b0;
        bus.compare_i = '0;
        bus.reach_result_3 = 1'b0;
    endtask

    task automatic load_code(logic [11:0] c);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            idle();
            bus.colour_in = c[n*3 +: 3];
            lc[n] = 1'b1;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic load_guess(logic [11:0] g);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            idle();
            bus.colour_in = g[n*3 +: 3];
            lg[n] = 1'b1;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic step(int i, bit r);
        @(negedge clk);
        idle();
        bus.compare = 1'b1;
        bus.compare_i = 2'(i);
        bus.reach_result_3 = r;
    endtask

    task automatic score();
        step(0, 1'b0);
        step(1, 1'b0);
        step(2, 1'b0);
        step(3, 1'b1);
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        vecs[0] = '{code: p4(1,2,3,4), guess: p4(1,2,3,4), eb: 3'd4, ew: 3'd0, ewin: 1'b1};
        vecs[1] = '{code: p4(1,2,3,4), guess: p4(4,3,2,1), eb: 3'd0, ew: 3'd4, ewin: 1'b0};
        vecs[2] = '{code: p4(1,1,2,2), guess: p4(1,2,1,1), eb: 3'd1, ew: 3'd2, ewin: 1'b0};
        vecs[3] = '{code: p4(5,5,5,6), guess: p4(6,5,0,0), eb: 3'd1, ew: 3'd1, ewin: 1'b0};
        vecs[4] = '{code: p4(7,7,7,7), guess: p4(7,0,7,0), eb: 3'd2, ew: 3'd0, ewin: 1'b0};
        vecs[5] = '{code: p4(0,1,2,3), guess: p4(1,0,3,2), eb: 3'd0, ew: 3'd4, ewin: 1'b0};
        vecs[6] = '{code: p4(1,2,3,4), guess: p4(1,2,4,3), eb: 3'd2, ew: 3'd2, ewin: 1'b0};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_out("reset", 0, 0, 0, 0, 0, 0);

        for (int v = 0; v < 7; v++) begin
            load_code(vecs[v].code);
            load_guess(vecs[v].guess);
            score();
            check_out($sformatf("vec%0d", v), int'(vecs[v].eb), int'(vecs[v].ew), 1, 1,
                      int'(vecs[v].ewin), 0);
        end

        // Ten wrong guesses lose the game; then everything is frozen.
        load_code(p4(1,2,3,4));
        for (int k = 1; k <= 9; k++) begin
            load_guess(p4(0,0,0,0));
            score();
            check($sformatf("lose_run%0d.gcount", k), int'(bus.guess_count), k);
            check($sformatf("lose_run%0d.lose", k), int'(bus.lose), 0);
        end
        load_guess(p4(0,0,0,0));
        score();
        check_out("tenth", 0, 0, 1, 10, 0, 1);
        load_guess(p4(1,2,3,4));
        score();
        check_out("after_lose", 0, 0, 1, 10, 0, 1);
        load_code(p4(1,2,3,4));
        check_out("new_game", 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-sequence, checked before any clock edge.
        load_guess(p4(1,2,4,3));
        score();
        check_out("pre_reset", 2, 2, 1, 1, 0, 0);
        step(0, 1'b0);
        step(1, 1'b0);
        #2 reset = 1'b1;
        #1 check_out("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        idle();
        reset = 1'b0;

        // Out-of-order and truncated sequences leave the old score in place.
        load_code(p4(1,2,3,4));
        load_guess(p4(1,2,4,3));
        score();
        check_out("rescore", 2, 2, 1, 1, 0, 0);
        step(0, 1'b0);
        step(2, 1'b0);
        step(3, 1'b1);
        @(negedge clk);
        idle();
        check_out("skip_seq", 2, 2, 0, 1, 0, 0);
        step(0, 1'b0);
        step(1, 1'b0);
        step(2, 1'b1);
        @(negedge clk);
        idle();
        check_out("early_r3", 2, 2, 0, 1, 0, 0);

        // Guess load during step 0: peg 0 is scored with the old colour.
        step(0, 1'b0);
        lg[0] = 1'b1;
        bus.colour_in = 3'd0;
        step(1, 1'b0);
        step(2, 1'b0);
        step(3, 1'b1);
        @(negedge clk);
        idle();
        check_out("load_during_cmp", 2, 2, 1, 2, 0, 0);

        // Held guess strobe keeps the last colour.
        load_code(p4(0,7,0,0));
        load_guess(p4(1,1,1,1));
        for (int c = 3; c <= 7; c += 2) begin
            @(negedge clk);
            idle();
            lg[1] = 1'b1;
            bus.colour_in = 3'(c);
        end
        @(negedge clk);
        idle();
        score();
        check_out("held_strobe", 1, 0, 1, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
